// File: rtl/sd_read_stream_dat_if.sv
// Control/data side of the SD DAT receive stream: block arm request in, byte strobes
// and block status out towards the function/FIFO and CMD/response logic.
interface sd_read_stream_dat_if #(
    parameter int MAX_BLOCK = 512
);
    localparam int BS_W = $clog2(MAX_BLOCK + 1);

    // Handshake: there is no ready/backpressure. start_read, data_strobe and read_done are
    // single-cycle pulses; block_size is sampled with start_read; data is valid on
    // data_strobe and held until the next one; crc_ok/timeout are valid with read_done.
    logic            start_read;
    logic [BS_W-1:0] block_size;
    logic            data_strobe;
    logic [7:0]      data;
    logic            read_done;
    logic            crc_ok;
    logic            timeout;
    logic            busy;

    modport master (
        output start_read, block_size,
        input  data_strobe, data, read_done, crc_ok, timeout, busy
    );

    modport slave (
        input  start_read, block_size,
        output data_strobe, data, read_done, crc_ok, timeout, busy
    );
endinterface

// File: rtl/sd_read_stream_dat.sv
// SD 4-bit DAT block receiver: start nibble detect, byte assembly, per-line CRC16
// check and end nibble check, oversampling sd_clock in the system clock domain.
module sd_crc16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        in,
    output logic [15:0] crc
);
    logic fb;
    assign fb = in ^ crc[15];

    // CRC16-CCITT, x^16 + x^12 + x^5 + 1, zero seed, MSB-first.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            crc <= 16'h0000;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end
endmodule

module sd_read_stream_dat #(
    parameter int MAX_BLOCK     = 512,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sd_clock,
    input  logic [3:0]            sd_data,
    sd_read_stream_dat_if.slave   ctrl,
    output logic [2:0]            dbg_state
);
    localparam int BS_W = $clog2(MAX_BLOCK + 1);
    localparam int TO_W = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_FULL = TO_W'(START_TIMEOUT);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_START = 3'd1;
    localparam logic [2:0] S_READ_HI    = 3'd2;
    localparam logic [2:0] S_READ_LO    = 3'd3;
    localparam logic [2:0] S_READ_CRC   = 3'd4;
    localparam logic [2:0] S_READ_END   = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]      state;
    logic [2:0]      clk_sync;
    logic [3:0]      dat_s1;
    logic [3:0]      dat_s2;
    logic            tick;
    logic [3:0]      nib;
    logic [BS_W-1:0] remaining;
    logic [TO_W-1:0] edge_cnt;
    logic [3:0]      bit_cnt;
    logic [3:0]      hi_nib;
    logic [15:0]     rx_crc  [4];
    logic [15:0]     crc_out [4];
    logic            crc_en;
    logic            crc_match;
    logic            strobe_q;
    logic [7:0]      data_q;
    logic            done_q;
    logic            crc_ok_q;
    logic            timeout_q;
    logic            busy_q;

    // Data takes the same two-flop path as the clock so a nibble sampled on the
    // tick is the value present when sd_clock rose.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 3'b000;
            dat_s1   <= 4'h0;
            dat_s2   <= 4'h0;
        end else begin
            clk_sync <= {clk_sync[1:0], sd_clock};
            dat_s1   <= sd_data;
            dat_s2   <= dat_s1;
        end
    end

    assign tick   = clk_sync[1] & ~clk_sync[2];
    assign nib    = dat_s2;
    assign crc_en = tick && !ctrl.start_read && (state == S_READ_HI || state == S_READ_LO);

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16 u_crc (
            .clock  (clock),
            .reset  (reset),
            .clear  (ctrl.start_read),
            .enable (crc_en),
            .in     (nib[i]),
            .crc    (crc_out[i])
        );
    end

    always_comb begin
        crc_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rx_crc[i] != crc_out[i]) crc_match = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            edge_cnt  <= '0;
            bit_cnt   <= 4'd0;
            hi_nib    <= 4'h0;
            strobe_q  <= 1'b0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < 4; i++) rx_crc[i] <= 16'h0000;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (ctrl.start_read) begin
                // A new request while a block is in flight aborts it with a failed status.
                if (state != S_IDLE) done_q <= 1'b1;
                state     <= S_WAIT_START;
                remaining <= ctrl.block_size;
                edge_cnt  <= '0;
                busy_q    <= 1'b1;
                crc_ok_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_WAIT_START: begin
                        if (tick) begin
                            if (nib == 4'h0) begin
                                state <= S_READ_HI;
                            end else begin
                                if (edge_cnt != TO_FULL) edge_cnt <= edge_cnt + 1'b1;
                                if (edge_cnt >= TO_LAST) begin
                                    timeout_q <= 1'b1;
                                    crc_ok_q  <= 1'b0;
                                    state     <= S_DONE;
                                end
                            end
                        end
                    end
                    S_READ_HI: begin
                        if (tick) begin
                            hi_nib <= nib;
                            state  <= S_READ_LO;
                        end
                    end
                    S_READ_LO: begin
                        if (tick) begin
                            data_q    <= {hi_nib, nib};
                            strobe_q  <= 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == BS_W'(1)) begin
                                bit_cnt <= 4'd15;
                                state   <= S_READ_CRC;
                            end else begin
                                state <= S_READ_HI;
                            end
                        end
                    end
                    S_READ_CRC: begin
                        if (tick) begin
                            for (int i = 0; i < 4; i++) rx_crc[i] <= {rx_crc[i][14:0], nib[i]};
                            if (bit_cnt == 4'd0) state <= S_READ_END;
                            else bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    S_READ_END: begin
                        if (tick) begin
                            crc_ok_q <= crc_match && (nib == 4'hF);
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ctrl.data_strobe = strobe_q;
    assign ctrl.data        = data_q;
    assign ctrl.read_done   = done_q;
    assign ctrl.crc_ok      = crc_ok_q;
    assign ctrl.timeout     = timeout_q;
    assign ctrl.busy        = busy_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_sd_read_stream_dat.sv
// Bench for sd_read_stream_dat: host-side DAT nibble driver, byte/status monitor and
// a polynomial-division CRC16 reference model.
module tb_sd_read_stream_dat;
    localparam int MAX_BLOCK     = 512;
    localparam int START_TIMEOUT = 1024;
    localparam int BS_W          = $clog2(MAX_BLOCK + 1);

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       sd_clock = 1'b1;
    logic [3:0] sd_data  = 4'hF;
    logic [2:0] dbg_state;

    sd_read_stream_dat_if #(.MAX_BLOCK(MAX_BLOCK)) ctrl ();

    sd_read_stream_dat #(.MAX_BLOCK(MAX_BLOCK), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .sd_clock  (sd_clock),
        .sd_data   (sd_data),
        .ctrl      (ctrl),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_mem [0:8191];
    int         got_cnt  = 0;
    int         done_cnt = 0;
    logic       done_crc_ok  = 1'b0;
    logic       done_timeout = 1'b0;
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];

    // Monitor: records every strobed byte and the status seen with each read_done.
    always @(negedge clock) begin
        if (ctrl.data_strobe) begin
            if (got_cnt < 8192) got_mem[got_cnt] = ctrl.data;
            got_cnt++;
        end
        if (ctrl.read_done) begin
            done_cnt++;
            done_crc_ok  = ctrl.crc_ok;
            done_timeout = ctrl.timeout;
        end
    end

    // CRC16 of one DAT line as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] line_crc(input int line);
        bit          msg [$];
        logic [7:0]  b;
        logic [16:0] g;
        logic [15:0] r;
        int          len;
        g = 17'h11021;
        foreach (tx_q[k]) begin
            b = tx_q[k];
            msg.push_back(b[4+line]);
            msg.push_back(b[line]);
        end
        len = msg.size();
        repeat (16) msg.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            if (msg[i]) begin
                for (int j = 0; j < 17; j++) msg[i+j] = msg[i+j] ^ g[16-j];
            end
        end
        for (int j = 0; j < 16; j++) r[15-j] = msg[len+j];
        return r;
    endfunction

    task automatic nib(input logic [3:0] n);
        @(negedge clock);
        sd_clock = 1'b0;
        sd_data  = n;
        repeat (3) @(negedge clock);
        sd_clock = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic pulse_start(input int size);
        @(negedge clock);
        ctrl.block_size = BS_W'(size);
        ctrl.start_read = 1'b1;
        @(negedge clock);
        ctrl.start_read = 1'b0;
    endtask

    task automatic send_prefix(input int nbytes);
        logic [7:0] b;
        repeat (2) nib(4'($urandom_range(1, 15)));
        nib(4'h0);
        for (int k = 0; k < nbytes; k++) begin
            b = tx_q[k];
            nib(b[7:4]);
            nib(b[3:0]);
        end
    endtask

    task automatic send_tail(input int flip_line, input int flip_bit, input logic [3:0] end_nib);
        logic [15:0] c [4];
        logic [3:0]  n;
        for (int i = 0; i < 4; i++) c[i] = line_crc(i);
        if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) n[i] = c[i][15-k];
            nib(n);
        end
        nib(end_nib);
        nib(4'hF);
    endtask

    task automatic wait_done(input int d_base, input string name);
        int w = 0;
        while (done_cnt == d_base && w < 300) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (done_cnt == d_base) begin
            errors++;
            $display("FAIL %s_done_wait: got no read_done within %0d cycles, want one", name, w);
        end
    endtask

    // Full block scenario: expected bytes are exactly tx_q; crc_ok only for clean CRC and end 1111.
    task automatic run_block(input string name, input bit do_start, input int flip_line,
                             input int flip_bit, input logic [3:0] end_nib);
        int   g_base = got_cnt;
        int   d_base = done_cnt;
        logic exp_ok = (flip_line < 0) && (end_nib == 4'hF);
        exp_q = tx_q;
        if (do_start) pulse_start(tx_q.size());
        send_prefix(tx_q.size());
        send_tail(flip_line, flip_bit, end_nib);
        wait_done(d_base, name);
        repeat (3) @(negedge clock);
        checks++;
        if (got_cnt - g_base !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_strobes: got %0d want %0d", name, got_cnt - g_base, exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (g_base + k < got_cnt) begin
                checks++;
                if (got_mem[g_base+k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h want %h", name, k, got_mem[g_base+k], exp_q[k]);
                end
            end
        end
        checks++;
        if (done_cnt - d_base !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d_base);
        end
        checks++;
        if (done_crc_ok !== exp_ok) begin
            errors++;
            $display("FAIL %s_crc_ok: got %b want %b", name, done_crc_ok, exp_ok);
        end
        checks++;
        if (done_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: got %b want 0", name, done_timeout);
        end
        checks++;
        if (ctrl.busy !== 1'b0 || ctrl.crc_ok !== exp_ok) begin
            errors++;
            $display("FAIL %s_idle_status: got busy %b crc_ok %b want busy 0 crc_ok %b",
                     name, ctrl.busy, ctrl.crc_ok, exp_ok);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({ctrl.data_strobe, ctrl.data, ctrl.read_done, ctrl.crc_ok, ctrl.timeout, ctrl.busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got strobe %b data %h done %b ok %b to %b busy %b want all 0",
                     ctrl.data_strobe, ctrl.data, ctrl.read_done, ctrl.crc_ok, ctrl.timeout, ctrl.busy);
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (ctrl.busy !== 1'b0 || done_cnt !== 0 || got_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b done %0d strobes %0d want 0 0 0", ctrl.busy, done_cnt, got_cnt);
        end
    endtask

    task automatic test_basic();
        tx_q = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        run_block("basic", 1'b1, -1, 0, 4'hF);
    endtask

    task automatic test_crc_error();
        tx_q = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        run_block("crc_flip", 1'b1, 2, 0, 4'hF);
    endtask

    task automatic test_bad_end();
        tx_q = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        run_block("bad_end", 1'b1, -1, 0, 4'h7);
    endtask

    task automatic test_timeout();
        int g_base = got_cnt;
        int d_base = done_cnt;
        pulse_start(4);
        repeat (START_TIMEOUT - 1) nib(4'hF);
        checks++;
        if (done_cnt !== d_base || ctrl.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got done %0d busy %b want done %0d busy 1", done_cnt, ctrl.busy, d_base);
        end
        nib(4'hF);
        wait_done(d_base, "timeout");
        repeat (2) @(negedge clock);
        checks++;
        if (done_timeout !== 1'b1 || done_crc_ok !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: got timeout %b crc_ok %b want 1 0", done_timeout, done_crc_ok);
        end
        checks++;
        if (got_cnt !== g_base || ctrl.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_quiet: got strobes %0d busy %b want 0 0", got_cnt - g_base, ctrl.busy);
        end
    endtask

    task automatic test_max_block();
        tx_q.delete();
        for (int k = 0; k < MAX_BLOCK; k++) tx_q.push_back(8'(k));
        run_block("max_block", 1'b1, -1, 0, 4'hF);
        tx_q = '{8'h5A};
        run_block("size1", 1'b1, -1, 0, 4'hF);
    endtask

    task automatic test_random();
        int          n;
        int          fl;
        logic [3:0]  en;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 24);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            fl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            run_block("random", 1'b1, fl, $urandom_range(0, 15), en);
        end
    endtask

    task automatic test_reset_mid();
        int d_base;
        int g_base;
        tx_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        d_base = done_cnt;
        g_base = got_cnt;
        pulse_start(4);
        send_prefix(2);
        checks++;
        if (got_cnt - g_base !== 2) begin
            errors++;
            $display("FAIL reset_mid_pre: got %0d strobes want 2", got_cnt - g_base);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({ctrl.data_strobe, ctrl.data, ctrl.read_done, ctrl.crc_ok, ctrl.timeout, ctrl.busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got strobe %b data %h done %b ok %b to %b busy %b want all 0",
                     ctrl.data_strobe, ctrl.data, ctrl.read_done, ctrl.crc_ok, ctrl.timeout, ctrl.busy);
        end
        repeat (3) nib(4'hF);
        checks++;
        if (done_cnt !== d_base) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d read_done want 0", done_cnt - d_base);
        end
        run_block("after_reset", 1'b1, -1, 0, 4'hF);
    endtask

    task automatic test_abort();
        int         d_base = done_cnt;
        int         g_base = got_cnt;
        logic [7:0] b;
        tx_q = '{8'h11, 8'h22, 8'h33};
        pulse_start(3);
        send_prefix(1);
        b = tx_q[1];
        nib(b[7:4]);
        pulse_start(2);
        wait_done(d_base, "abort");
        checks++;
        if (done_crc_ok !== 1'b0 || done_timeout !== 1'b0 || ctrl.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_status: got crc_ok %b timeout %b busy %b want 0 0 1",
                     done_crc_ok, done_timeout, ctrl.busy);
        end
        checks++;
        if (got_cnt - g_base !== 1 || got_mem[g_base] !== 8'h11) begin
            errors++;
            $display("FAIL abort_bytes: got %0d strobes first %h want 1 strobe 11", got_cnt - g_base, got_mem[g_base]);
        end
        tx_q = '{8'($urandom), 8'($urandom)};
        run_block("rearmed", 1'b0, -1, 0, 4'hF);
    endtask

    initial begin
        ctrl.start_read = 1'b0;
        ctrl.block_size = '0;
        test_reset();
        test_basic();
        test_crc_error();
        test_bad_end();
        test_timeout();
        test_max_block();
        test_random();
        test_reset_mid();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
